osg_pulse_sequencer: RTL and testbench



---
 rtl/osg_seq_pkg.sv | 23 ++
 rtl/osg_seq_timer.sv | 29 ++
 rtl/osg_pulse_sequencer.sv | 179 +++++++++++++++++
 tb/tb_osg_pulse_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/osg_seq_pkg.sv
// Shared types and helpers for the optical sync generator pulse sequencer.
// Latency: not applicable (types, constants and a pure function only).
// Backpressure: not applicable.
package osg_seq_pkg;

  localparam int OSG_CNT_W  = 17;
  localparam int OSG_MULT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_GAP,
    ST_FIN
  } osg_state_e;

  // Prescaled length count*(mul+1). The result is wide enough that callers
  // can keep the full CNT_W+MULT_W bits without losing anything.
  function automatic logic [63:0] osg_scaled_len(input logic [31:0] cnt,
                                                 input logic [31:0] mul);
    return {32'd0, cnt} * ({32'd0, mul} + 64'd1);
  endfunction

endpackage

// File: rtl/osg_seq_timer.sv
// Loadable down-counter shared by the pulse and gap phases of the sequencer.
// Latency: a load of length N expires on the max(N,1)-th cycle after the load.
// Backpressure: none; the load strobe always wins over counting.
module osg_seq_timer #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Count down to zero and stay there; zero and one both mean "last cycle".
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt[W-1:1] == '0);

endmodule

// File: rtl/osg_pulse_sequencer.sv
// Chained pulse/gap sequencer walking N_CH channels per launch (OSG_REPEAT_EN adds repeat passes).
// Latency: start edge sampled at cycle k drives channel 0 from cycle k+1; all outputs registered.
// Backpressure: none; start edges while busy are ignored and abort wins over everything.
module osg_pulse_sequencer
  import osg_seq_pkg::*;
#(
  parameter int N_CH   = 16,
  parameter int CNT_W  = OSG_CNT_W,
  parameter int MULT_W = OSG_MULT_W,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
`ifdef OSG_REPEAT_EN
  , parameter int REP_W = 8
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_CH*CNT_W-1:0]    dur_flat,
  input  logic [N_CH*CNT_W-1:0]    del_flat,
  input  logic [N_CH*MULT_W-1:0]   pmul_flat,
  input  logic [N_CH*MULT_W-1:0]   dmul_flat,
`ifdef OSG_REPEAT_EN
  input  logic [REP_W-1:0]         repeat_n,
`endif
  output logic [N_CH-1:0]          ch_out,
  output logic                     busy,
  output logic                     done,
  output logic [CH_W-1:0]          cur_ch
);

  localparam int LW = CNT_W + MULT_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  osg_state_e state, state_d;
  logic [CH_W-1:0] ch, ch_d, nxt_ch;
  logic start_q, snap, more_pass;
  logic [N_CH*CNT_W-1:0]  dur_q, del_q;
  logic [N_CH*MULT_W-1:0] pmul_q, dmul_q;
  logic tmr_load, tmr_exp;
  logic [LW-1:0] tmr_len, launch_len, next_len, gap_len;
  logic [N_CH-1:0] ch_out_d;
`ifdef OSG_REPEAT_EN
  logic [REP_W-1:0] pass_q, pass_d;
`endif

  // A zero-length pulse still takes its cycle but keeps the output low.
  function automatic logic [N_CH-1:0] pulse_bits(input logic [CH_W-1:0] idx,
                                                 input logic [LW-1:0]   len);
    logic [N_CH-1:0] r;
    r = '0;
    if (len != '0) r[idx] = 1'b1;
    return r;
  endfunction

  assign nxt_ch     = (ch == LAST_CH) ? '0 : ch + 1'b1;
  // Channel 0 length comes straight from the inputs: the snapshot is being
  // captured on the very same edge.
  assign launch_len = LW'(osg_scaled_len(32'(dur_flat[CNT_W-1:0]),
                                         32'(pmul_flat[MULT_W-1:0])));
  assign next_len   = LW'(osg_scaled_len(32'(dur_q[int'(nxt_ch)*CNT_W +: CNT_W]),
                                         32'(pmul_q[int'(nxt_ch)*MULT_W +: MULT_W])));
  assign gap_len    = LW'(osg_scaled_len(32'(del_q[int'(ch)*CNT_W +: CNT_W]),
                                         32'(dmul_q[int'(ch)*MULT_W +: MULT_W])));
`ifdef OSG_REPEAT_EN
  assign more_pass = (pass_q != '0);
`else
  assign more_pass = 1'b0;
`endif

  osg_seq_timer #(.W(LW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_exp)
  );

  // Next-state, timer load and next output pattern.
  always_comb begin
    state_d  = state;
    ch_d     = ch;
    snap     = 1'b0;
    tmr_load = 1'b0;
    tmr_len  = next_len;
    ch_out_d = ch_out;
`ifdef OSG_REPEAT_EN
    pass_d   = pass_q;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !start_q) begin
          snap     = 1'b1;
          ch_d     = '0;
          tmr_load = 1'b1;
          tmr_len  = launch_len;
          ch_out_d = pulse_bits('0, launch_len);
          state_d  = ST_PULSE;
`ifdef OSG_REPEAT_EN
          pass_d   = repeat_n;
`endif
        end
      end
      ST_PULSE: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_len  = gap_len;
          ch_out_d = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_exp) begin
          if (ch != LAST_CH || more_pass) begin
            ch_d     = nxt_ch;
            tmr_load = 1'b1;
            tmr_len  = next_len;
            ch_out_d = pulse_bits(nxt_ch, next_len);
            state_d  = ST_PULSE;
`ifdef OSG_REPEAT_EN
            if (ch == LAST_CH) pass_d = pass_q - 1'b1;
`endif
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      ch_d     = ch;
      snap     = 1'b0;
      tmr_load = 1'b0;
      ch_out_d = '0;
    end
  end

  // State, start history and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ch      <= '0;
      start_q <= 1'b1;
      ch_out  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      ch      <= ch_d;
      start_q <= start;
      ch_out  <= ch_out_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_FIN);
    end
  end

  // Configuration snapshot taken only at launch.
  always_ff @(posedge clk) begin
    if (snap) begin
      dur_q  <= dur_flat;
      del_q  <= del_flat;
      pmul_q <= pmul_flat;
      dmul_q <= dmul_flat;
    end
  end

`ifdef OSG_REPEAT_EN
  // Remaining repeat passes for the running sequence.
  always_ff @(posedge clk) begin
    if (rst) pass_q <= '0;
    else     pass_q <= pass_d;
  end
`endif

  assign cur_ch = ch;

endmodule

// File: tb/tb_osg_pulse_sequencer.sv
module tb_osg_pulse_sequencer;
  localparam int NCH = 4;
  localparam int CW  = 6;
  localparam int MW  = 3;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [NCH*CW-1:0] dur_flat, del_flat;
  logic [NCH*MW-1:0] pmul_flat, dmul_flat;
  logic [NCH-1:0]    ch_out;
  logic              busy, done;
  logic [1:0]        cur_ch;
`ifdef OSG_REPEAT_EN
  logic [7:0]        rep_drv = 8'd0;
`endif

  int nerr = 0;
  int nchk = 0;
  int dur_a[NCH], del_a[NCH], pm_a[NCH], dm_a[NCH];
  int reps = 0;
  logic [NCH-1:0] expq[$];
  int             expch[$];

  always #5 clk = ~clk;

  osg_pulse_sequencer #(.N_CH(NCH), .CNT_W(CW), .MULT_W(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .dur_flat  (dur_flat),
    .del_flat  (del_flat),
    .pmul_flat (pmul_flat),
    .dmul_flat (dmul_flat),
`ifdef OSG_REPEAT_EN
    .repeat_n  (rep_drv),
`endif
    .ch_out    (ch_out),
    .busy      (busy),
    .done      (done),
    .cur_ch    (cur_ch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < NCH; i++) begin
      dur_flat[i*CW +: CW]  = CW'(dur_a[i]);
      del_flat[i*CW +: CW]  = CW'(del_a[i]);
      pmul_flat[i*MW +: MW] = MW'(pm_a[i]);
      dmul_flat[i*MW +: MW] = MW'(dm_a[i]);
    end
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < NCH; i++) begin
      dur_a[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 9));
      del_a[i] = int'($urandom_range(0, 4));
      pm_a[i]  = int'($urandom_range(0, 2));
      dm_a[i]  = int'($urandom_range(0, 2));
    end
  endtask

  // Expected per-cycle waveform from launch+1 up to (not including) done.
  function automatic void build_exp();
    int l, g;
    expq.delete();
    expch.delete();
    for (int p = 0; p <= reps; p++) begin
      for (int i = 0; i < NCH; i++) begin
        l = dur_a[i] * (pm_a[i] + 1);
        g = del_a[i] * (dm_a[i] + 1);
        if (l == 0) begin
          expq.push_back('0);
          expch.push_back(i);
        end else begin
          for (int c = 0; c < l; c++) begin
            expq.push_back(NCH'(1) << i);
            expch.push_back(i);
          end
        end
        for (int c = 0; c < ((g == 0) ? 1 : g); c++) begin
          expq.push_back('0);
          expch.push_back(i);
        end
      end
    end
  endfunction

  task automatic run_seq(input string tag, input bit scramble, input bit toggle);
    int n;
    build_exp();
    n = expq.size();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int j = 0; j < n; j++) begin
      chk({tag, "_ch_out"}, 32'(ch_out), 32'(expq[j]));
      chk({tag, "_cur_ch"}, 32'(cur_ch), 32'(expch[j]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      if (j >= n - 2) start = 1'b0;
      else if (toggle) start = 1'($urandom_range(0, 1));
      if (scramble && j == 1) begin
        rand_cfg();
        drive_cfg();
      end
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_ch_out"}, 32'(ch_out), 32'd0);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit found;
    int dones;
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      dur_a[i] = 1; del_a[i] = 1; pm_a[i] = 0; dm_a[i] = 0;
    end
    drive_cfg();
    repeat (3) tick();
    chk("rst_ch_out", 32'(ch_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cur_ch", 32'(cur_ch), 32'd0);

    // Start held high through reset release must not launch.
    rst = 1'b0;
    repeat (4) tick();
    chk("held_start_busy", 32'(busy), 32'd0);
    chk("held_start_ch_out", 32'(ch_out), 32'd0);
    start = 1'b0;
    tick();

    // Directed example: durations 5/3/0/2, gaps 2, no prescale.
    dur_a = '{5, 3, 0, 2};
    del_a = '{2, 2, 2, 2};
    pm_a  = '{0, 0, 0, 0};
    dm_a  = '{0, 0, 0, 0};
    drive_cfg();
    run_seq("example", 1'b0, 1'b0);

    // Prescaled pulse: 4*(2+1)=12 cycles, plus zero gaps between channels.
    dur_a = '{4, 1, 2, 0};
    del_a = '{0, 0, 3, 0};
    pm_a  = '{2, 0, 1, 3};
    dm_a  = '{0, 5, 1, 0};
    drive_cfg();
    run_seq("prescale_zero_gap", 1'b0, 1'b0);

    // Full-scale counts exercise the full-width product (504 cycles each).
    dur_a = '{63, 63, 63, 63};
    del_a = '{63, 63, 63, 63};
    pm_a  = '{7, 7, 7, 7};
    dm_a  = '{7, 7, 7, 7};
    drive_cfg();
    run_seq("max_len", 1'b0, 1'b0);

    // Random configurations with start toggling while busy.
    for (int r = 0; r < 6; r++) begin
      rand_cfg();
      drive_cfg();
      run_seq("random", 1'b0, 1'b1);
    end

    // Config changed during channel 0: this run keeps old values, next uses new.
    rand_cfg();
    dur_a[0] = 6;
    drive_cfg();
    run_seq("cfg_old", 1'b1, 1'b0);
    run_seq("cfg_new", 1'b0, 1'b0);

    // Abort in the middle of channel 2's pulse.
    dur_a = '{3, 4, 6, 5};
    del_a = '{1, 2, 1, 1};
    pm_a  = '{0, 0, 0, 0};
    dm_a  = '{0, 0, 0, 0};
    drive_cfg();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (cur_ch == 2'd2 && ch_out[2]) found = 1'b1;
      else tick();
    end
    chk("abort_reach_ch2", 32'(found), 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ch_out", 32'(ch_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_seq("post_abort", 1'b0, 1'b0);

    // Abort held in IDLE blocks a rising start; holding start gives no new edge.
    abort = 1'b1;
    start = 1'b1;
    tick();
    tick();
    chk("abort_idle_busy", 32'(busy), 32'd0);
    abort = 1'b0;
    tick();
    tick();
    chk("abort_idle_no_edge", 32'(busy), 32'd0);
    start = 1'b0;
    tick();

`ifdef OSG_REPEAT_EN
    // Three back-to-back passes with a single done.
    rand_cfg();
    drive_cfg();
    reps = 2;
    rep_drv = 8'd2;
    run_seq("repeat", 1'b0, 1'b0);
    reps = 0;
    rep_drv = 8'd0;
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
